// File: rtl/sseg_display_ctrl.sv
// Hex display controller: shadow register with load/ready handshake, frame-aligned
// commit, active-low static and multiplexed segment outputs, leading-zero blanking and blink.
module sseg_display_ctrl #(
    parameter int NUM_DIGITS = 6,
    parameter int SCAN_DIV   = 50_000,
    parameter int BLINK_DIV  = 25_000_000
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      load,
    input  logic [4*NUM_DIGITS-1:0]   data,
    output logic                      ready,
    input  logic                      blank_lz,
    input  logic                      blink_en,
    output logic [7*NUM_DIGITS-1:0]   segs,
    output logic [6:0]                scan_seg,
    output logic [NUM_DIGITS-1:0]     scan_an
);

    localparam int DW = 4 * NUM_DIGITS;
    localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    logic [DW-1:0]           shadow_q, shadow_d, disp_q, disp_d;
    logic                    pending_q, pending_d, ready_q, ready_d;
    logic [SW-1:0]           scan_cnt_q, scan_cnt_d;
    logic [IW-1:0]           scan_idx_q, scan_idx_d;
    logic [BW-1:0]           blink_cnt_q, blink_cnt_d;
    logic                    blink_ph_q, blink_ph_d;
    logic [7*NUM_DIGITS-1:0] segs_q, segs_d;
    logic [6:0]              scan_seg_q, scan_seg_d;
    logic [NUM_DIGITS-1:0]   scan_an_q, scan_an_d;

    logic       scan_tc, frame_end, blink_tc, accept;
    logic       zero_run;
    logic [3:0] digit;
    logic [6:0] glyph;

    function automatic logic [6:0] hex_glyph(input logic [3:0] h);
        case (h)
            4'h0: hex_glyph = 7'h40;
            4'h1: hex_glyph = 7'h79;
            4'h2: hex_glyph = 7'h24;
            4'h3: hex_glyph = 7'h30;
            4'h4: hex_glyph = 7'h19;
            4'h5: hex_glyph = 7'h12;
            4'h6: hex_glyph = 7'h02;
            4'h7: hex_glyph = 7'h78;
            4'h8: hex_glyph = 7'h00;
            4'h9: hex_glyph = 7'h10;
            4'hA: hex_glyph = 7'h08;
            4'hB: hex_glyph = 7'h03;
            4'hC: hex_glyph = 7'h46;
            4'hD: hex_glyph = 7'h21;
            4'hE: hex_glyph = 7'h06;
            default: hex_glyph = 7'h0E;
        endcase
    endfunction

    always_comb begin
        scan_tc   = (scan_cnt_q == SW'(SCAN_DIV - 1));
        frame_end = scan_tc && (scan_idx_q == IW'(NUM_DIGITS - 1));
        blink_tc  = (blink_cnt_q == BW'(BLINK_DIV - 1));
        accept    = load && ready_q;

        scan_cnt_d  = scan_tc ? '0 : scan_cnt_q + SW'(1);
        scan_idx_d  = scan_idx_q;
        if (scan_tc) begin
            scan_idx_d = (scan_idx_q == IW'(NUM_DIGITS - 1)) ? '0 : scan_idx_q + IW'(1);
        end
        blink_cnt_d = blink_tc ? '0 : blink_cnt_q + BW'(1);
        blink_ph_d  = blink_ph_q ^ blink_tc;

        shadow_d  = shadow_q;
        disp_d    = disp_q;
        pending_d = pending_q;
        ready_d   = ready_q;
        // ready implies nothing pending, so commit and accept never coincide
        if (frame_end && pending_q) begin
            disp_d    = shadow_q;
            pending_d = 1'b0;
            ready_d   = 1'b1;
        end
        if (accept) begin
            shadow_d  = data;
            pending_d = 1'b1;
            ready_d   = 1'b0;
        end
    end

    // Walk digits from most significant down so zero_run tracks "all higher digits are zero"
    always_comb begin
        zero_run   = 1'b1;
        digit      = '0;
        glyph      = '1;
        segs_d     = '1;
        scan_seg_d = '1;
        scan_an_d  = '1;
        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            digit    = disp_q[4*(NUM_DIGITS-1-i) +: 4];
            zero_run = zero_run && (digit == 4'h0);
            glyph    = hex_glyph(digit);
            if ((blank_lz && zero_run && (i != NUM_DIGITS - 1)) || (blink_en && blink_ph_q)) begin
                glyph = 7'h7F;
            end
            segs_d[7*(NUM_DIGITS-1-i) +: 7] = glyph;
            if (scan_idx_q == IW'(NUM_DIGITS - 1 - i)) begin
                scan_seg_d                  = glyph;
                scan_an_d[NUM_DIGITS-1-i]   = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            shadow_q    <= '0;
            disp_q      <= '0;
            pending_q   <= 1'b0;
            ready_q     <= 1'b1;
            scan_cnt_q  <= '0;
            scan_idx_q  <= '0;
            blink_cnt_q <= '0;
            blink_ph_q  <= 1'b0;
            segs_q      <= '1;
            scan_seg_q  <= '1;
            scan_an_q   <= '1;
        end else begin
            shadow_q    <= shadow_d;
            disp_q      <= disp_d;
            pending_q   <= pending_d;
            ready_q     <= ready_d;
            scan_cnt_q  <= scan_cnt_d;
            scan_idx_q  <= scan_idx_d;
            blink_cnt_q <= blink_cnt_d;
            blink_ph_q  <= blink_ph_d;
            segs_q      <= segs_d;
            scan_seg_q  <= scan_seg_d;
            scan_an_q   <= scan_an_d;
        end
    end

    assign ready    = ready_q;
    assign segs     = segs_q;
    assign scan_seg = scan_seg_q;
    assign scan_an  = scan_an_q;

endmodule

// File: tb/tb_sseg_display_ctrl.sv
// Randomised self-checking bench for sseg_display_ctrl against a cycle-count based
// reference model (slot, frame and blink phase derived arithmetically from time since reset).
module tb_sseg_display_ctrl;

    localparam int ND    = 4;
    localparam int SD    = 4;
    localparam int BD    = 16;
    localparam int FRAME = ND * SD;

    logic        clk = 1'b0;
    logic        reset, load, blank_lz, blink_en, ready;
    logic [15:0] data;
    logic [27:0] segs;
    logic [6:0]  scan_seg;
    logic [3:0]  scan_an;

    int n_checks = 0;
    int n_fail   = 0;

    int unsigned t;
    logic        m_ready, m_pending;
    logic [15:0] m_shadow, m_disp;
    logic [27:0] e_segs;
    logic [6:0]  e_scan_seg;
    logic [3:0]  e_scan_an;

    logic [6:0] glyph_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                   7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    sseg_display_ctrl #(.NUM_DIGITS(ND), .SCAN_DIV(SD), .BLINK_DIV(BD)) dut (
        .clk(clk), .reset(reset), .load(load), .data(data), .ready(ready),
        .blank_lz(blank_lz), .blink_en(blink_en), .segs(segs),
        .scan_seg(scan_seg), .scan_an(scan_an)
    );

    always #5 clk = ~clk;

    function automatic logic [27:0] model_segs(input logic [15:0] v, input logic lz, input logic blank_all);
        logic [27:0] r;
        r = '1;
        for (int k = 0; k < ND; k++) begin
            if (blank_all || (lz && k != 0 && (v >> (4 * k)) == 16'h0))
                r[7*k +: 7] = 7'h7F;
            else
                r[7*k +: 7] = glyph_tab[v[4*k +: 4]];
        end
        return r;
    endfunction

    // Advance one clock, updating the model from the inputs presented before the edge.
    task automatic tick();
        logic r, l, bz, be, ph;
        logic [15:0] d;
        int unsigned slot;
        r = reset; l = load; d = data; bz = blank_lz; be = blink_en;
        @(posedge clk);
        if (r) begin
            t = 0; m_ready = 1'b1; m_pending = 1'b0; m_shadow = '0; m_disp = '0;
            e_segs = '1; e_scan_seg = '1; e_scan_an = '1;
        end else begin
            slot       = (t / SD) % ND;
            ph         = ((t / BD) % 2) == 1;
            e_segs     = model_segs(m_disp, bz, be && ph);
            e_scan_seg = e_segs[7*slot +: 7];
            e_scan_an  = ~(4'b0001 << slot);
            if ((t % FRAME) == FRAME - 1 && m_pending) begin
                m_disp = m_shadow; m_pending = 1'b0; m_ready = 1'b1;
            end else if (l && m_ready) begin
                m_shadow = d; m_pending = 1'b1; m_ready = 1'b0;
            end
            t++;
        end
        #1;
    endtask

    task automatic load_wait(input logic [15:0] d);
        int n;
        n = 0;
        while (ready !== 1'b1 && n < 2 * FRAME + 2) begin tick(); n++; end
        load = 1'b1; data = d;
        tick();
        load = 1'b0;
        n = 0;
        while (ready !== 1'b1 && n < 2 * FRAME + 2) begin
            tick(); n++;
            n_checks++;
            if (segs !== e_segs || ready !== m_ready) begin
                n_fail++;
                $display("FAIL load_wait_cycle t=%0d: segs=%h ready=%b, expected segs=%h ready=%b", t, segs, ready, e_segs, m_ready);
            end
        end
        n_checks++;
        if (ready !== 1'b1) begin
            n_fail++;
            $display("FAIL commit_timeout: ready=%b after %0d cycles, expected 1", ready, n);
        end
        tick();
    endtask

    task automatic test_reset();
        reset = 1'b1; load = 1'b0; data = '0; blank_lz = 1'b0; blink_en = 1'b0;
        tick(); tick();
        n_checks++;
        if (segs !== 28'hFFFFFFF || scan_an !== 4'hF || scan_seg !== 7'h7F || ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_state: segs=%h scan_an=%h scan_seg=%h ready=%b, expected FFFFFFF F 7f 1", segs, scan_an, scan_seg, ready);
        end
        reset = 1'b0;
        tick();
        n_checks++;
        if (segs !== {4{7'h40}} || segs !== e_segs) begin
            n_fail++;
            $display("FAIL reset_zero_display: segs=%h, expected %h", segs, {4{7'h40}});
        end
    endtask

    task automatic test_load_commit();
        int low;
        while (t < 5) tick();
        load = 1'b1; data = 16'h1A3F;
        tick();
        load = 1'b0;
        low = 0;
        for (int i = 0; i < 20 && ready !== 1'b1; i++) begin
            if (ready === 1'b0) low++;
            tick();
        end
        n_checks++;
        if (low != 10 || ready !== 1'b1) begin
            n_fail++;
            $display("FAIL load_ready_low: low cycles=%0d ready=%b, expected 10 and 1", low, ready);
        end
        tick();
        n_checks++;
        if (segs !== {7'h79, 7'h08, 7'h30, 7'h0E}) begin
            n_fail++;
            $display("FAIL load_commit_segs: segs=%h, expected %h", segs, {7'h79, 7'h08, 7'h30, 7'h0E});
        end
    endtask

    task automatic test_lz();
        blank_lz = 1'b1;
        load_wait(16'h0050);
        n_checks++;
        if (segs !== {7'h7F, 7'h7F, 7'h12, 7'h40}) begin
            n_fail++;
            $display("FAIL lz_0050: segs=%h, expected %h", segs, {7'h7F, 7'h7F, 7'h12, 7'h40});
        end
        load_wait(16'h0000);
        n_checks++;
        if (segs !== {7'h7F, 7'h7F, 7'h7F, 7'h40}) begin
            n_fail++;
            $display("FAIL lz_0000: segs=%h, expected %h", segs, {7'h7F, 7'h7F, 7'h7F, 7'h40});
        end
        blank_lz = 1'b0;
    endtask

    task automatic test_scan();
        load_wait(16'hC0D9);
        for (int i = 0; i < 3 * FRAME; i++) begin
            tick();
            n_checks++;
            if (scan_an !== e_scan_an || scan_seg !== e_scan_seg) begin
                n_fail++;
                $display("FAIL scan t=%0d: scan_an=%h scan_seg=%h, expected %h %h", t, scan_an, scan_seg, e_scan_an, e_scan_seg);
            end
        end
    endtask

    task automatic test_blink();
        int blanked;
        blink_en = 1'b1;
        blanked = 0;
        for (int i = 0; i < 4 * BD; i++) begin
            tick();
            if (segs === 28'hFFFFFFF) blanked++;
            n_checks++;
            if (segs !== e_segs || scan_seg !== e_scan_seg) begin
                n_fail++;
                $display("FAIL blink t=%0d: segs=%h scan_seg=%h, expected %h %h", t, segs, scan_seg, e_segs, e_scan_seg);
            end
        end
        n_checks++;
        if (blanked != 2 * BD) begin
            n_fail++;
            $display("FAIL blink_duty: blanked cycles=%0d, expected %0d", blanked, 2 * BD);
        end
        blink_en = 1'b0;
        for (int i = 0; i < 2 * BD; i++) begin
            tick();
            n_checks++;
            if (segs === 28'hFFFFFFF || segs !== e_segs) begin
                n_fail++;
                $display("FAIL blink_off t=%0d: segs=%h, expected %h", t, segs, e_segs);
            end
        end
    endtask

    task automatic test_boundary_load();
        int low;
        for (int i = 0; i < 3 * FRAME && !((t % FRAME) == FRAME - 1 && ready === 1'b1); i++) tick();
        load = 1'b1; data = 16'hBEEF;
        tick();
        load = 1'b0;
        n_checks++;
        if (ready !== 1'b0) begin
            n_fail++;
            $display("FAIL boundary_accept: ready=%b, expected 0", ready);
        end
        low = 0;
        for (int i = 0; i < FRAME; i++) begin
            tick();
            if (ready === 1'b0) low++;
        end
        n_checks++;
        if (low != FRAME - 1 || ready !== 1'b1) begin
            n_fail++;
            $display("FAIL boundary_commit: low=%0d ready=%b, expected %0d and 1", low, ready, FRAME - 1);
        end
        tick();
        n_checks++;
        if (segs !== {7'h03, 7'h06, 7'h06, 7'h0E}) begin
            n_fail++;
            $display("FAIL boundary_segs: segs=%h, expected %h", segs, {7'h03, 7'h06, 7'h06, 7'h0E});
        end
    endtask

    task automatic test_back_to_back();
        int n;
        load = 1'b1; data = 16'h1234;
        tick();
        data = 16'h5678;
        tick(); tick(); tick();
        load = 1'b0;
        n = 0;
        while (ready !== 1'b1 && n < 2 * FRAME + 2) begin tick(); n++; end
        tick();
        n_checks++;
        if (segs !== {7'h79, 7'h24, 7'h30, 7'h19} || segs !== e_segs) begin
            n_fail++;
            $display("FAIL second_load_ignored: segs=%h, expected %h", segs, {7'h79, 7'h24, 7'h30, 7'h19});
        end
    endtask

    task automatic test_reset_pending();
        load = 1'b1; data = 16'hABCD;
        tick();
        load = 1'b0;
        tick(); tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        n_checks++;
        if (ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_pending_ready: ready=%b, expected 1", ready);
        end
        for (int i = 0; i < 2 * FRAME + 4; i++) tick();
        n_checks++;
        if (segs !== {4{7'h40}} || ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_pending_disp: segs=%h ready=%b, expected %h 1", segs, ready, {4{7'h40}});
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            load     = ($urandom_range(0, 3) == 0);
            data     = 16'($urandom) >> (4 * $urandom_range(0, 4));
            blank_lz = 1'($urandom);
            blink_en = ($urandom_range(0, 3) == 0);
            tick();
            n_checks++;
            if (segs !== e_segs || scan_seg !== e_scan_seg || scan_an !== e_scan_an || ready !== m_ready) begin
                n_fail++;
                $display("FAIL random t=%0d: segs=%h seg=%h an=%h rdy=%b, expected %h %h %h %b",
                         t, segs, scan_seg, scan_an, ready, e_segs, e_scan_seg, e_scan_an, m_ready);
            end
        end
        load = 1'b0; blink_en = 1'b0; blank_lz = 1'b0;
    endtask

    initial begin
        test_reset();
        test_load_commit();
        test_lz();
        test_scan();
        test_blink();
        test_boundary_load();
        test_back_to_back();
        test_reset_pending();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
